alu_rr_sched: RTL and testbench

- Round-robin scheduler that shares one ALU_design instance between N requesters.
- Each requester presents a complete operation (operands, CMD, MODE, CIN, INP_VALID) with a valid/ready handshake.
- The scheduler issues one operation at a time, holds the ALU inputs stable for the ALU's pipeline latency and captures RES and flags.
- It returns the result, tagged with the requester ID, on a single response channel.

---
 rtl/alu_rr_sched.sv | 195 +++++++++++++++++++
 tb/tb_alu_rr_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU between N_REQ requesters.
// Each operation is issued, held for the ALU latency, and answered on one response channel.
module alu_rr_sched #(
    parameter int N_REQ     = 4,
    parameter int WIDTH_O   = 8,
    parameter int WIDTH_C   = 4,
    parameter int WIDTH_RES = 2 * WIDTH_O,
    parameter int LAT_STD   = 2,
    parameter int LAT_MUL   = 3,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [N_REQ-1:0]           REQ_VALID,
    output logic [N_REQ-1:0]           REQ_READY,
    input  logic [N_REQ*WIDTH_O-1:0]   REQ_OPA,
    input  logic [N_REQ*WIDTH_O-1:0]   REQ_OPB,
    input  logic [N_REQ*WIDTH_C-1:0]   REQ_CMD,
    input  logic [N_REQ-1:0]           REQ_MODE,
    input  logic [N_REQ-1:0]           REQ_CIN,
    input  logic [N_REQ*2-1:0]         REQ_INP_VALID,
    output logic [WIDTH_O-1:0]         ALU_OPA,
    output logic [WIDTH_O-1:0]         ALU_OPB,
    output logic [WIDTH_C-1:0]         ALU_CMD,
    output logic                       ALU_MODE,
    output logic                       ALU_CIN,
    output logic                       ALU_CE,
    output logic [1:0]                 ALU_INP_VALID,
    input  logic [WIDTH_RES-1:0]       ALU_RES,
    input  logic                       ALU_COUT,
    input  logic                       ALU_OFLOW,
    input  logic                       ALU_G,
    input  logic                       ALU_E,
    input  logic                       ALU_L,
    input  logic                       ALU_ERR,
    output logic                       RSP_VALID,
    input  logic                       RSP_READY,
    output logic [ID_W-1:0]            RSP_ID,
    output logic [WIDTH_RES-1:0]       RSP_RES,
    output logic [5:0]                 RSP_FLAGS,
    output logic                       BUSY
);

    localparam int LAT_MAX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
    localparam int CNT_W   = (LAT_MAX > 0) ? $clog2(LAT_MAX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    grant_id;
    logic               grant_vld;
    logic [N_REQ-1:0]   ready_c;
    logic               accept;
    logic               capture;
    logic               rsp_done;

    logic [WIDTH_O-1:0] sel_opa, sel_opb;
    logic [WIDTH_C-1:0] sel_cmd;
    logic               sel_mode, sel_cin;
    logic [1:0]         sel_iv;

    logic [ID_W-1:0]    op_id_p0;
    logic [WIDTH_O-1:0] op_opa_p0, op_opb_p0;
    logic [WIDTH_C-1:0] op_cmd_p0;
    logic               op_mode_p0, op_cin_p0;
    logic [1:0]         op_iv_p0;
    logic [CNT_W-1:0]   cnt_p0;

    function automatic logic lat_is_mul(input logic mode, input logic [WIDTH_C-1:0] cmd);
        return mode && ((cmd == WIDTH_C'(9)) || (cmd == WIDTH_C'(10)));
    endfunction

    // Walk the ring from the far end back so the nearest valid requester to ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (REQ_VALID[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        sel_opa  = REQ_OPA[grant_id*WIDTH_O +: WIDTH_O];
        sel_opb  = REQ_OPB[grant_id*WIDTH_O +: WIDTH_O];
        sel_cmd  = REQ_CMD[grant_id*WIDTH_C +: WIDTH_C];
        sel_mode = REQ_MODE[grant_id];
        sel_cin  = REQ_CIN[grant_id];
        sel_iv   = REQ_INP_VALID[grant_id*2 +: 2];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ready_c  = '0;
        accept   = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    ready_c[grant_id] = 1'b1;
                    accept            = 1'b1;
                    state_d           = EXEC;
                end
            end
            EXEC: begin
                if (cnt_p0 == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // READY is combinational, so it is also masked while reset is held.
    assign REQ_READY = RST_N ? ready_c : '0;
    assign BUSY      = (state_q != IDLE);
    assign ALU_CE    = (state_q == EXEC);

    assign ALU_OPA       = op_opa_p0;
    assign ALU_OPB       = op_opb_p0;
    assign ALU_CMD       = op_cmd_p0;
    assign ALU_MODE      = op_mode_p0;
    assign ALU_CIN       = op_cin_p0;
    assign ALU_INP_VALID = op_iv_p0;

    // Stage p0: operation registers, held through EXEC and RESP.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_id_p0   <= '0;
            op_opa_p0  <= '0;
            op_opb_p0  <= '0;
            op_cmd_p0  <= '0;
            op_mode_p0 <= 1'b0;
            op_cin_p0  <= 1'b0;
            op_iv_p0   <= '0;
            cnt_p0     <= '0;
            ptr_q      <= '0;
            RSP_VALID  <= 1'b0;
            RSP_ID     <= '0;
            RSP_RES    <= '0;
            RSP_FLAGS  <= '0;
        end else begin
            if (accept) begin
                op_id_p0   <= grant_id;
                op_opa_p0  <= sel_opa;
                op_opb_p0  <= sel_opb;
                op_cmd_p0  <= sel_cmd;
                op_mode_p0 <= sel_mode;
                op_cin_p0  <= sel_cin;
                op_iv_p0   <= sel_iv;
                cnt_p0     <= lat_is_mul(sel_mode, sel_cmd) ? CNT_W'(LAT_MUL) : CNT_W'(LAT_STD);
            end else if ((state_q == EXEC) && (cnt_p0 != '0)) begin
                cnt_p0 <= cnt_p0 - 1'b1;
            end

            // Response stage: capture on the last EXEC edge.
            if (capture) begin
                RSP_VALID <= 1'b1;
                RSP_ID    <= op_id_p0;
                RSP_RES   <= ALU_RES;
                RSP_FLAGS <= {ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR};
            end

            if (rsp_done) begin
                RSP_VALID <= 1'b0;
                ptr_q     <= (op_id_p0 == ID_W'(N_REQ - 1)) ? '0 : op_id_p0 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with a small latency-accurate ALU stand-in.
module tb_alu_rr_sched;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  REQ_VALID = '0;
    logic [3:0]  REQ_READY;
    logic [31:0] REQ_OPA = '0;
    logic [31:0] REQ_OPB = '0;
    logic [15:0] REQ_CMD = '0;
    logic [3:0]  REQ_MODE = '0;
    logic [3:0]  REQ_CIN = '0;
    logic [7:0]  REQ_INP_VALID = '0;
    logic [7:0]  ALU_OPA, ALU_OPB;
    logic [3:0]  ALU_CMD;
    logic        ALU_MODE, ALU_CIN, ALU_CE;
    logic [1:0]  ALU_INP_VALID;
    logic [15:0] ALU_RES;
    logic        ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic [1:0]  RSP_ID;
    logic [15:0] RSP_RES;
    logic [5:0]  RSP_FLAGS;
    logic        BUSY;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    always #5 CLK = ~CLK;

    alu_rr_sched dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD),
        .REQ_MODE(REQ_MODE), .REQ_CIN(REQ_CIN), .REQ_INP_VALID(REQ_INP_VALID),
        .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CMD(ALU_CMD),
        .ALU_MODE(ALU_MODE), .ALU_CIN(ALU_CIN), .ALU_CE(ALU_CE),
        .ALU_INP_VALID(ALU_INP_VALID),
        .ALU_RES(ALU_RES), .ALU_COUT(ALU_COUT), .ALU_OFLOW(ALU_OFLOW),
        .ALU_G(ALU_G), .ALU_E(ALU_E), .ALU_L(ALU_L), .ALU_ERR(ALU_ERR),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS), .BUSY(BUSY)
    );

    // ALU stand-in: {RES, COUT, OFLOW, G, E, L, ERR}, RES appears after 2 (3 for multiply) CE edges.
    function automatic logic [21:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] c, input logic m);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (m) begin
            case (c)
                4'd0:    return {7'd0, sum, sum[8], 5'b00000};
                4'd9:    return {16'((a + 16'd1) * (b + 16'd1)), 6'b000000};
                4'd10:   return {16'({a, 1'b0} * b), 6'b000000};
                default: return {16'd0, 6'b000001};
            endcase
        end else begin
            case (c)
                4'd0:    return {8'd0, a & b, 6'b000000};
                default: return {16'd0, 6'b000001};
            endcase
        end
    endfunction

    logic [21:0] s1 = '0, s2 = '0, s3 = '0;
    always @(posedge CLK) begin
        if (ALU_CE) begin
            s1 <= alu_f(ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE);
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign {ALU_RES, ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR} =
        (ALU_MODE && (ALU_CMD == 4'd9 || ALU_CMD == 4'd10)) ? s3 : s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] c, input logic m);
        REQ_OPA[i*8 +: 8]       = a;
        REQ_OPB[i*8 +: 8]       = b;
        REQ_CMD[i*4 +: 4]       = c;
        REQ_MODE[i]             = m;
        REQ_CIN[i]              = 1'b0;
        REQ_INP_VALID[i*2 +: 2] = 2'b11;
    endtask

    task automatic wait_rsp(output int cnt);
        cnt = 0;
        while (!RSP_VALID && cnt < 20) begin
            tick();
            cnt++;
        end
        check("rsp_arrived", RSP_VALID, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state, with a request already pending.
        REQ_VALID = 4'b0001;
        tick(); tick();
        check("rst_ready", REQ_READY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ce", ALU_CE, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_alu_opa", ALU_OPA, 0);
        check("rst_rsp_res", RSP_RES, 0);
        REQ_VALID = 4'b0000;
        RST_N = 1'b1;
        tick();

        // Single ADD on requester 0.
        set_req(0, 8'h0F, 8'h01, 4'd0, 1'b1);
        REQ_VALID = 4'b0001;
        RSP_READY = 1'b1;
        #1;
        check("add_ready", REQ_READY, 4'b0001);
        check("add_idle_busy", BUSY, 0);
        tick();
        REQ_VALID = 4'b0000;
        #1;
        check("add_busy", BUSY, 1);
        check("add_ce", ALU_CE, 1);
        check("add_alu_opa", ALU_OPA, 8'h0F);
        check("add_alu_opb", ALU_OPB, 8'h01);
        check("add_exec_ready", REQ_READY, 0);
        tick();
        check("add_valid_e1", RSP_VALID, 0);
        tick();
        check("add_valid_e2", RSP_VALID, 0);
        tick();
        check("add_valid_e3", RSP_VALID, 1);
        check("add_res", RSP_RES, 16'h0010);
        check("add_id", RSP_ID, 0);
        check("add_flags", RSP_FLAGS, 0);
        check("add_resp_ce", ALU_CE, 0);
        tick();
        check("add_done_valid", RSP_VALID, 0);
        check("add_done_busy", BUSY, 0);

        // Multiply latency on requester 2: (3+1)*(4+1).
        set_req(2, 8'd3, 8'd4, 4'd9, 1'b1);
        REQ_VALID = 4'b0100;
        wait_rsp(n);
        REQ_VALID = 4'b0000;
        check("mul_latency", n, 5);
        check("mul_res", RSP_RES, 16'd20);
        check("mul_id", RSP_ID, 2);
        tick();

        // Error pass-through on requester 3.
        set_req(3, 8'h55, 8'hAA, 4'b1110, 1'b0);
        REQ_VALID = 4'b1000;
        wait_rsp(n);
        REQ_VALID = 4'b0000;
        check("err_latency", n, 4);
        check("err_flags", RSP_FLAGS, 6'b000001);
        check("err_res", RSP_RES, 0);
        check("err_id", RSP_ID, 3);
        tick();

        // Fairness: all four requesting, pointer back at 0.
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'hFF, 4'd0, 1'b0);
        REQ_VALID = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_rsp(n);
            if (r == 4) REQ_VALID = 4'b0000;
            check("rr_interval", n, 4);
            check("rr_id", RSP_ID, r % 4);
            check("rr_res", RSP_RES, (r % 4) + 1);
            tick();
        end

        // Backpressure on requester 1 while requester 3 waits.
        set_req(1, 8'h20, 8'h22, 4'd0, 1'b1);
        set_req(3, 8'h3C, 8'h0F, 4'd0, 1'b0);
        RSP_READY = 1'b0;
        REQ_VALID = 4'b0010;
        wait_rsp(n);
        REQ_VALID = 4'b1000;
        check("bp_latency", n, 4);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", RSP_VALID, 1);
            check("bp_res", RSP_RES, 16'h0042);
            check("bp_id", RSP_ID, 1);
            check("bp_ready", REQ_READY, 0);
            check("bp_busy", BUSY, 1);
            tick();
        end
        RSP_READY = 1'b1;
        tick();
        check("bp_release_valid", RSP_VALID, 0);
        check("bp_next_ready", REQ_READY, 4'b1000);
        tick();
        REQ_VALID = 4'b0000;
        check("bp_next_busy", BUSY, 1);
        wait_rsp(n);
        check("bp_next_latency", n, 3);
        check("bp_next_res", RSP_RES, 16'h000C);
        check("bp_next_id", RSP_ID, 3);
        tick();

        // Requester 1 completes, leaving the pointer at 2.
        set_req(1, 8'h05, 8'h06, 4'd0, 1'b1);
        REQ_VALID = 4'b0010;
        wait_rsp(n);
        REQ_VALID = 4'b0000;
        check("r1_res", RSP_RES, 16'h000B);
        check("r1_id", RSP_ID, 1);
        tick();

        // Reset in EXEC cycle 2 of a requester 2 multiply.
        set_req(2, 8'h07, 8'h07, 4'd9, 1'b1);
        set_req(1, 8'h10, 8'h01, 4'd0, 1'b1);
        REQ_VALID = 4'b0100;
        tick();
        REQ_VALID = 4'b1010;
        tick();
        RST_N = 1'b0;
        #1;
        check("arst_busy", BUSY, 0);
        check("arst_ce", ALU_CE, 0);
        check("arst_alu_opa", ALU_OPA, 0);
        check("arst_alu_cmd", ALU_CMD, 0);
        check("arst_alu_mode", ALU_MODE, 0);
        check("arst_rsp_valid", RSP_VALID, 0);
        check("arst_ready", REQ_READY, 0);
        tick();
        RST_N = 1'b1;
        #1;
        check("arst_regrant", REQ_READY, 4'b0010);
        wait_rsp(n);
        REQ_VALID = 4'b0000;
        check("arst_latency", n, 4);
        check("arst_id", RSP_ID, 1);
        check("arst_res", RSP_RES, 16'h0011);
        tick();
        check("arst_end_busy", BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
